// File: rtl/fetch_queue_unit_if.sv
// Bundles the fetch unit's instruction-memory request/response channel and its
// valid/ready handoff to decode.
interface fetch_queue_unit_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 16
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic [3:0]         id_opcode;

    modport master (
        output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch stage: credit-limited request issue, in-order prefetch queue and
// redirect flush. Optional HALT stop on opcode 4'hF is enabled by `define FETCH_HALT_EN.
module fetch_queue_unit #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    fetch_queue_unit_if.master bus
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop;
    logic [PTR_W-1:0]   q_head;
    logic [PTR_W-1:0]   q_tail;
    logic [PTR_W-1:0]   pf_head;
    logic [PTR_W-1:0]   pf_tail;
    logic [INSTR_W-1:0] q_instr [QDEPTH];
    logic [ADDR_W-1:0]  q_pc    [QDEPTH];
    logic [ADDR_W-1:0]  pc_fifo [QDEPTH];

    logic               halt_q;
    logic [CNT_W:0]     in_use;
    logic               credit_ok;
    logic               req_fire;
    logic               rsp_drop;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head_instr;

    // Credits cover queued entries plus every request still in flight, stale or not.
    assign in_use    = (CNT_W+1)'(count) + (CNT_W+1)'(outstanding);
    assign credit_ok = in_use < (CNT_W+1)'(QDEPTH);

    assign bus.imem_req_valid = !rst && !redirect && credit_ok && !halt_q;
    assign bus.imem_addr      = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_drop = bus.imem_rsp_valid && (drop != '0);
    assign push     = bus.imem_rsp_valid && (drop == '0) && !halt_q;
    assign pop      = (count != '0) && bus.id_ready;

    assign head_instr    = q_instr[q_head];
    assign bus.id_valid  = (count != '0);
    assign bus.id_instr  = head_instr;
    assign bus.id_pc     = q_pc[q_head];
    assign bus.id_opcode = head_instr[INSTR_W-1 -: 4];

`ifdef FETCH_HALT_EN
    // Sticky stop once a HALT enters the queue; only reset or redirect resume fetch.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            halt_q <= 1'b0;
        end else if (push && (bus.imem_rsp_data[INSTR_W-1 -: 4] == 4'hF)) begin
            halt_q <= 1'b1;
        end
    end
    assign halted = halt_q;
`else
    assign halt_q = 1'b0;
    assign halted = 1'b0;
`endif

    // Control state: PC, credit counters and queue/PC-FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
        end else if (redirect) begin
            // Nothing issues this cycle, so all remaining in-flight responses are stale.
            fetch_pc    <= redirect_pc;
            count       <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
            outstanding <= outstanding - CNT_W'(bus.imem_rsp_valid);
            drop        <= outstanding - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                pf_tail  <= pf_tail + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (rsp_drop) begin
                drop <= drop - CNT_W'(1);
            end
            // Dropped responses have no PC FIFO entry; halt-discarded ones do.
            if (bus.imem_rsp_valid && !rsp_drop) begin
                pf_head <= pf_head + PTR_W'(1);
            end
            if (push) begin
                q_tail <= q_tail + PTR_W'(1);
            end
            if (pop) begin
                q_head <= q_head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage arrays; pointers reset above make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_fifo[pf_tail] <= fetch_pc;
        end
        if (push) begin
            q_instr[q_tail] <= bus.imem_rsp_data;
            q_pc[q_tail]    <= pc_fifo[pf_head];
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit: an in-order memory model plus a
// queue-level scoreboard of the instruction stream decode should see.
module tb_fetch_queue_unit;

    localparam int QDEPTH = 4;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    fetch_queue_unit_if #(.INSTR_W(16), .ADDR_W(16)) bus ();

    fetch_queue_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          stale;
    int          req_count;
    int          del_count;
    logic        halted_m;
    logic        saw_halt;
    logic [15:0] exp_addr;
    logic [15:0] halt_addr;
    logic [15:0] last_del_pc;
    logic [15:0] last_req_addr;
    logic [15:0] after_fffe;
    mreq_t       mem_q[$];
    exp_t        exp_q[$];

    // Memory image; top bit kept clear so only halt_addr holds a 4'hF opcode.
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        logic [15:0] v;
        if (a == halt_addr) return 16'hF000;
        v = a * 16'd7 + 16'h1357;
        return {1'b0, v[14:0]};
    endfunction

    task automatic model_clear();
        mem_q.delete();
        exp_q.delete();
        stale    = 0;
        halted_m = 1'b0;
        exp_addr = 16'h0000;
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 16'h0000;
        bus.id_ready       = 1'b0;
        redirect           = 1'b0;
        redirect_pc        = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One clock: drive inputs, compare against the scoreboard, then advance the model.
    task automatic drive_cycle(input logic rdy, input logic idr, input logic redir,
                               input logic [15:0] rpc);
        logic  exp_rv;
        logic  req_f;
        logic  id_f;
        logic  rsp_f;
        logic  hold_halt;
        mreq_t r;
        exp_t  e;
        @(negedge clk);
        cyc++;
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        redirect           = redir;
        redirect_pc        = rpc;
        rsp_f = 1'b0;
        if (mem_q.size() > 0) rsp_f = (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rsp_f;
        bus.imem_rsp_data  = 16'h0000;
        if (rsp_f) bus.imem_rsp_data = mem_data(mem_q[0].addr);
        #1;
        exp_rv = !redir && ((exp_q.size() + mem_q.size()) < QDEPTH) && !halted_m;
        checks++;
        if (bus.imem_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc %0d got %0b exp %0b", cyc, bus.imem_req_valid, exp_rv);
        end
        checks++;
        if (bus.id_valid !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL id_valid cyc %0d got %0b exp %0b", cyc, bus.id_valid, exp_q.size() > 0);
        end
        checks++;
        if (halted !== halted_m) begin
            errors++;
            $display("FAIL halted cyc %0d got %0b exp %0b", cyc, halted, halted_m);
        end
        checks++;
        if ((exp_q.size() + mem_q.size()) > QDEPTH) begin
            errors++;
            $display("FAIL credit cyc %0d queued %0d inflight %0d", cyc, exp_q.size(), mem_q.size());
        end
        req_f = bus.imem_req_valid && rdy;
        id_f  = bus.id_valid && idr;
        if (id_f && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_pc !== e.pc) begin
                errors++;
                $display("FAIL id_pc cyc %0d got %h exp %h", cyc, bus.id_pc, e.pc);
            end
            checks++;
            if (bus.id_instr !== e.instr) begin
                errors++;
                $display("FAIL id_instr cyc %0d got %h exp %h", cyc, bus.id_instr, e.instr);
            end
            checks++;
            if (bus.id_opcode !== e.instr[15:12]) begin
                errors++;
                $display("FAIL id_opcode cyc %0d got %h exp %h", cyc, bus.id_opcode, e.instr[15:12]);
            end
            del_count++;
            last_del_pc = bus.id_pc;
            if (bus.id_pc == halt_addr && bus.id_instr == 16'hF000) saw_halt = 1'b1;
        end
        if (req_f) begin
            checks++;
            if (bus.imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL imem_addr cyc %0d got %h exp %h", cyc, bus.imem_addr, exp_addr);
            end
            if (last_req_addr == 16'hFFFE) after_fffe = bus.imem_addr;
            last_req_addr = bus.imem_addr;
            req_count++;
        end
        hold_halt = halted_m;
        if (rsp_f) begin
            r = mem_q.pop_front();
            if (stale > 0) begin
                stale--;
            end else if (!hold_halt) begin
                e.pc    = r.addr;
                e.instr = mem_data(r.addr);
                exp_q.push_back(e);
`ifdef FETCH_HALT_EN
                if (e.instr[15:12] == 4'hF) halted_m = 1'b1;
`endif
            end
        end
        if (req_f) begin
            r.addr = bus.imem_addr;
            r.due  = cyc + lat;
            mem_q.push_back(r);
            exp_addr = exp_addr + 16'd2;
        end
        if (redir) begin
            exp_q.delete();
            stale    = mem_q.size();
            exp_addr = rpc;
            halted_m = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_clear();
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %0b exp 0", bus.imem_req_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_id_valid got %0b exp 0", bus.id_valid);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted got %0b exp 0", halted);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_req got v=%0b a=%h exp v=1 a=0000", bus.imem_req_valid, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        int d0;
        do_reset();
        lat = 1;
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        d0 = del_count;
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (del_count - d0 != 10) begin
            errors++;
            $display("FAIL seq_throughput got %0d exp 10", del_count - d0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1;
        req_count = 0;
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (req_count != QDEPTH) begin
            errors++;
            $display("FAIL stall_requests got %0d exp %0d", req_count, QDEPTH);
        end
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_valid got %0b exp 0", bus.imem_req_valid);
        end
        del_count = 0;
        repeat (4) drive_cycle(1'b0, 1'b1, 1'b0, 16'h0);
        checks++;
        if (del_count != 4 || last_del_pc !== 16'h0006) begin
            errors++;
            $display("FAIL stall_drain got n=%0d pc=%h exp n=4 pc=0006", del_count, last_del_pc);
        end
    endtask

    task automatic test_redirect();
        int d0;
        int n;
        do_reset();
        lat = 3;
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        d0 = del_count;
        drive_cycle(1'b1, 1'b1, 1'b1, 16'h0040);
        drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush got id_valid=%0b exp 0", bus.id_valid);
        end
        n = 0;
        while (del_count == d0 && n < 20) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
            n++;
        end
        checks++;
        if (del_count == d0 || last_del_pc !== 16'h0040) begin
            errors++;
            $display("FAIL redir_target got n=%0d pc=%h exp pc=0040", del_count - d0, last_del_pc);
        end
    endtask

    task automatic test_toggle();
        int d0;
        do_reset();
        lat = 3;
        d0 = del_count;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(logic'(i % 2 == 0), logic'($urandom_range(0, 1)), 1'b0, 16'h0);
        end
        checks++;
        if (del_count == d0) begin
            errors++;
            $display("FAIL toggle_progress got 0 deliveries exp >0");
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        last_req_addr = 16'h0001;
        after_fffe    = 16'hDEAD;
        drive_cycle(1'b0, 1'b1, 1'b1, 16'hFFFC);
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (after_fffe !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap got %h exp 0000", after_fffe);
        end
    endtask

    task automatic test_halt();
        logic exp_h;
        do_reset();
        lat = 1;
        halt_addr = 16'h0006;
        saw_halt  = 1'b0;
`ifdef FETCH_HALT_EN
        exp_h = 1'b1;
`else
        exp_h = 1'b0;
`endif
        repeat (15) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (saw_halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_delivered got %0b exp 1", saw_halt);
        end
        checks++;
        if (halted !== exp_h) begin
            errors++;
            $display("FAIL halt_state got %0b exp %0b", halted, exp_h);
        end
        checks++;
        if (bus.imem_req_valid !== !exp_h) begin
            errors++;
            $display("FAIL halt_req_valid got %0b exp %0b", bus.imem_req_valid, !exp_h);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 16'h0010);
        drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (halted !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL halt_resume got h=%0b v=%0b a=%h exp h=0 v=1 a=0010",
                     halted, bus.imem_req_valid, bus.imem_addr);
        end
        halt_addr = 16'h0001;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            drive_cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0),
                        logic'($urandom_range(0, 24) == 0), {16'($urandom_range(0, 65535))} & 16'hFFFE);
        end
    endtask

    task automatic test_reset_mid();
        lat = 3;
        repeat (20) drive_cycle(1'b1, 1'b0, 1'b0, 16'h0);
        do_reset();
        checks++;
        if (bus.id_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got v=%0b h=%0b exp 0 0", bus.id_valid, halted);
        end
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_req got v=%0b a=%h exp v=1 a=0000", bus.imem_req_valid, bus.imem_addr);
        end
        repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        lat           = 1;
        req_count     = 0;
        del_count     = 0;
        saw_halt      = 1'b0;
        halt_addr     = 16'h0001;
        last_del_pc   = 16'h0000;
        last_req_addr = 16'h0001;
        after_fffe    = 16'hDEAD;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_toggle();
        test_wrap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
